// File: rtl/fu_issue_scheduler_pkg.sv
// fu_issue_scheduler_pkg: shared defaults, slot index type and popcount helper for the issue scheduler.
package fu_issue_scheduler_pkg;
   localparam int RS_ENTRIES_DEFAULT = 16;
   localparam int NUM_FU_DEFAULT     = 3;

   typedef logic [$clog2(RS_ENTRIES_DEFAULT)-1:0] rs_idx_t;

   function automatic logic [7:0] popcount(input logic [63:0] v);
      logic [7:0] c;
      c = '0;
      for (int i = 0; i < 64; i++) c += {7'd0, v[i]};
      return c;
   endfunction
endpackage

// File: rtl/fu_issue_scheduler_oldest_select.sv
// fu_issue_scheduler_oldest_select: picks the oldest candidate from a mask using the age matrix.
module fu_issue_scheduler_oldest_select
   import fu_issue_scheduler_pkg::*;
#(
   parameter int N = RS_ENTRIES_DEFAULT,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0]         cand,
   input  logic [N-1:0][N-1:0]  older,
   output logic [N-1:0]         win,
   output logic [W-1:0]         win_idx,
   output logic                 has_cand
);
   // A candidate wins when no other candidate is recorded as older than it.
   always_comb begin
      win = cand;
      win_idx = '0;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            if (cand[j] && older[j][i]) win[i] = 1'b0;
      for (int i = N - 1; i >= 0; i--)
         if (win[i]) win_idx = W'(i);
      has_cand = |cand;
   end
endmodule

// File: rtl/fu_issue_scheduler.sv
// fu_issue_scheduler: oldest-first issue of ready RS entries onto available FUs via an age matrix.
// Define FU_SCHED_PERF_EN to add saturating issue and starvation counters as extra outputs.
module fu_issue_scheduler
   import fu_issue_scheduler_pkg::*;
#(
   parameter int RS_ENTRIES = RS_ENTRIES_DEFAULT,
   parameter int NUM_FU     = NUM_FU_DEFAULT,
   parameter int IDX_W      = $clog2(RS_ENTRIES)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    alloc_valid,
   input  logic [IDX_W-1:0]        alloc_index,
   input  logic [RS_ENTRIES-1:0]   rs_ready,
   input  logic                    flush,
   input  logic [NUM_FU-1:0]       fu_is_available,
   output logic [NUM_FU-1:0]       fu_write_enable,
   output logic [NUM_FU*IDX_W-1:0] fu_entry_index,
   output logic [RS_ENTRIES-1:0]   rs_issued,
   output logic [IDX_W:0]          tracked_count
`ifdef FU_SCHED_PERF_EN
   ,
   output logic [31:0]             perf_issue_count,
   output logic [31:0]             perf_starve_cycles
`endif
);
   logic [RS_ENTRIES-1:0]                  valid_q, valid_d, elig, live;
   logic [RS_ENTRIES-1:0][RS_ENTRIES-1:0] older_q, older_d;
   logic [IDX_W:0]                         tracked_count_q, tracked_count_d;
   logic [RS_ENTRIES-1:0]                  pool [NUM_FU];
   logic [RS_ENTRIES-1:0]                  win [NUM_FU];
   logic [IDX_W-1:0]                       win_idx [NUM_FU];
   logic [NUM_FU-1:0]                      has_cand;

   assign elig    = valid_q & rs_ready & {RS_ENTRIES{!flush}};
   assign pool[0] = elig;

   for (genvar p = 0; p < NUM_FU; p++) begin : g_pick
      fu_issue_scheduler_oldest_select #(.N(RS_ENTRIES), .W(IDX_W)) u_sel (
         .cand     (pool[p]),
         .older    (older_q),
         .win      (win[p]),
         .win_idx  (win_idx[p]),
         .has_cand (has_cand[p])
      );
      if (p < NUM_FU - 1) begin : g_next
         assign pool[p+1] = pool[p] & ~win[p];
      end
   end

   // Pick n goes to the n-th available FU in ascending index order.
   always_comb begin
      int n;
      n = 0;
      fu_write_enable = '0;
      fu_entry_index = '0;
      rs_issued = '0;
      for (int k = 0; k < NUM_FU; k++)
         if (fu_is_available[k]) begin
            for (int q = 0; q < NUM_FU; q++)
               if (q == n && has_cand[q]) begin
                  fu_write_enable[k] = 1'b1;
                  fu_entry_index[k*IDX_W +: IDX_W] = win_idx[q];
                  rs_issued = rs_issued | win[q];
               end
            n++;
         end
   end

   // Issue clears first so a slot freed this cycle can be re-allocated as the youngest.
   always_comb begin
      live = valid_q & ~rs_issued;
      valid_d = live;
      older_d = older_q;
      if (flush) valid_d = '0;
      else if (alloc_valid) begin
         valid_d[alloc_index] = 1'b1;
         older_d[alloc_index] = '0;
         for (int j = 0; j < RS_ENTRIES; j++)
            if (live[j] && j != int'(alloc_index)) older_d[j][alloc_index] = 1'b1;
      end
      tracked_count_d = (IDX_W+1)'(popcount(64'(valid_d)));
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         valid_q <= '0;
         older_q <= '0;
         tracked_count_q <= '0;
      end else begin
         valid_q <= valid_d;
         older_q <= older_d;
         tracked_count_q <= tracked_count_d;
      end

   assign tracked_count = tracked_count_q;

`ifdef FU_SCHED_PERF_EN
   logic [31:0] perf_issue_count_q, perf_issue_count_d;
   logic [31:0] perf_starve_cycles_q, perf_starve_cycles_d;
   logic [32:0] issue_sum;

   always_comb begin
      issue_sum = {1'b0, perf_issue_count_q} + 33'(popcount(64'(fu_write_enable)));
      perf_issue_count_d = issue_sum[32] ? '1 : issue_sum[31:0];
      perf_starve_cycles_d = perf_starve_cycles_q
         + 32'((|elig) && !(|fu_write_enable) && !(&perf_starve_cycles_q));
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         perf_issue_count_q <= '0;
         perf_starve_cycles_q <= '0;
      end else begin
         perf_issue_count_q <= perf_issue_count_d;
         perf_starve_cycles_q <= perf_starve_cycles_d;
      end

   assign perf_issue_count = perf_issue_count_q;
   assign perf_starve_cycles = perf_starve_cycles_q;
`endif

   always @(posedge clk)
      if (!reset) begin
         if (alloc_valid && !flush && valid_q[alloc_index] && !rs_issued[alloc_index])
            $fatal(1, "Alloc to occupied RS slot");
         if (|(fu_write_enable & ~fu_is_available))
            $fatal(1, "Grant to unavailable FU");
      end
endmodule
